// File: rtl/softmax_row_packer.sv
// Row packer for the softmax block: rounds/saturates accumulator results to Q2.14
// and packs them into ping-pong row buffers presented with a valid/ready handshake.
module softmax_row_packer #(
    parameter int N         = 32,
    parameter int IN_WIDTH  = 32,
    parameter int IN_FRAC   = 16,
    parameter int BIT_WIDTH = 16,
    parameter int OUT_FRAC  = 14
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic signed [IN_WIDTH-1:0]  i_data,
    input  logic                        i_last,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [BIT_WIDTH-1:0] o_data [N],
    output logic                        o_sat,
    output logic [$clog2(N+1)-1:0]      o_pad
);

    localparam int SHIFT = IN_FRAC - OUT_FRAC;
    localparam int CW    = $clog2(N);
    localparam int PW    = $clog2(N+1);

    localparam logic signed [IN_WIDTH:0] RND   = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [IN_WIDTH:0] R_MAX =
        {{(IN_WIDTH-BIT_WIDTH+2){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] R_MIN =
        {{(IN_WIDTH-BIT_WIDTH+2){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [BIT_WIDTH-1:0] LANE_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] LANE_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic signed [BIT_WIDTH-1:0] row_q [2][N];
    logic signed [BIT_WIDTH-1:0] row_d [2][N];
    logic [1:0]                  full_q, full_d;
    logic [1:0]                  sat_q, sat_d;
    logic [PW-1:0]               pad_q [2];
    logic [PW-1:0]               pad_d [2];
    logic                        wr_q, wr_d;
    logic                        rd_q, rd_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    logic signed [IN_WIDTH:0]    sum;
    logic signed [IN_WIDTH:0]    rnd_val;
    logic signed [BIT_WIDTH-1:0] lane_val;
    logic                        lane_sat;
    logic                        accept;
    logic                        close;
    logic                        pop;

    // Round half up in IN_WIDTH+1 bits so the rounding add cannot overflow.
    always_comb begin
        sum     = {i_data[IN_WIDTH-1], i_data} + RND;
        rnd_val = sum >>> SHIFT;
        if (rnd_val > R_MAX) begin
            lane_val = LANE_MAX;
            lane_sat = 1'b1;
        end else if (rnd_val < R_MIN) begin
            lane_val = LANE_MIN;
            lane_sat = 1'b1;
        end else begin
            lane_val = rnd_val[BIT_WIDTH-1:0];
            lane_sat = 1'b0;
        end
    end

    assign o_ready = !full_q[wr_q];
    assign o_valid = full_q[rd_q];
    assign o_sat   = sat_q[rd_q];
    assign o_pad   = pad_q[rd_q];

    assign accept = i_valid && o_ready;
    assign close  = i_last || (cnt_q == CW'(N-1));
    assign pop    = full_q[rd_q] && i_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_data[i] = row_q[rd_q][i];
        end
    end

    always_comb begin
        row_d  = row_q;
        full_d = full_q;
        sat_d  = sat_q;
        pad_d  = pad_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;

        if (accept) begin
            row_d[wr_q][cnt_q] = lane_val;
            sat_d[wr_q]        = (cnt_q == '0) ? lane_sat : (sat_q[wr_q] | lane_sat);
            if (close) begin
                // Padded lanes carry the most negative value so exp() makes them ~0.
                for (int i = 0; i < N; i++) begin
                    if (i > int'(cnt_q)) begin
                        row_d[wr_q][i] = LANE_MIN;
                    end
                end
                pad_d[wr_q]  = PW'(N-1) - PW'(cnt_q);
                full_d[wr_q] = 1'b1;
                wr_d         = ~wr_q;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A pop can only target the other buffer when a close happens, so both apply.
        if (pop) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    row_q[b][i] <= '0;
                end
                pad_q[b] <= '0;
            end
            full_q <= '0;
            sat_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            row_q  <= row_d;
            pad_q  <= pad_d;
            full_q <= full_d;
            sat_q  <= sat_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_softmax_row_packer.sv
// Bench for softmax_row_packer: directed test-plan steps plus random traffic,
// checked against a row-queue reference model.
module tb_softmax_row_packer;

    localparam int N     = 32;
    localparam int IW    = 32;
    localparam int SHIFT = 2;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic signed [31:0] i_data = '0;
    logic               i_last = 1'b0;
    logic               o_valid;
    logic               i_ready = 1'b0;
    logic signed [15:0] o_data [N];
    logic               o_sat;
    logic [5:0]         o_pad;

    softmax_row_packer #(.N(N), .IN_WIDTH(IW), .IN_FRAC(16), .BIT_WIDTH(16), .OUT_FRAC(14)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_sat(o_sat), .o_pad(o_pad)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [N*16-1:0] lanes;
        logic            sat;
        logic [5:0]      pad;
    } row_t;

    row_t            rows [$];
    logic [N*16-1:0] cur;
    logic            cur_sat;
    int              cur_cnt;
    int              errors = 0;
    int              checks = 0;

    // Real-number view: value/4 rounded half up, then clipped to 16-bit range.
    function automatic void conv(input logic [31:0] d, output logic [15:0] y, output logic s);
        longint x, num, r;
        x   = longint'($signed(d));
        num = x + (64'sd1 << (SHIFT-1));
        if (num >= 0) r = num / (64'sd1 << SHIFT);
        else          r = -((-num + (64'sd1 << SHIFT) - 1) / (64'sd1 << SHIFT));
        s = 1'b0;
        if (r > 32767)       begin y = 16'h7FFF; s = 1'b1; end
        else if (r < -32768) begin y = 16'h8000; s = 1'b1; end
        else                 y = 16'(r);
    endfunction

    function automatic void model_accept(input logic [31:0] d, input logic l);
        logic [15:0] y;
        logic        s;
        row_t        r;
        conv(d, y, s);
        cur[cur_cnt*16 +: 16] = y;
        cur_sat = (cur_cnt == 0) ? s : (cur_sat | s);
        if (l || cur_cnt == N-1) begin
            for (int i = cur_cnt+1; i < N; i++) cur[i*16 +: 16] = 16'h8000;
            r.lanes = cur;
            r.sat   = cur_sat;
            r.pad   = 6'(N-1-cur_cnt);
            rows.push_back(r);
            cur_cnt = 0;
        end else begin
            cur_cnt++;
        end
    endfunction

    task automatic check_outputs();
        logic exp_rdy, exp_vld;
        exp_rdy = (rows.size() < 2);
        exp_vld = (rows.size() > 0);
        checks++;
        assert (o_ready === exp_rdy) else begin
            errors++;
            $error("FAIL o_ready observed=%0b expected=%0b t=%0t", o_ready, exp_rdy, $time);
        end
        checks++;
        assert (o_valid === exp_vld) else begin
            errors++;
            $error("FAIL o_valid observed=%0b expected=%0b t=%0t", o_valid, exp_vld, $time);
        end
        if (exp_vld) begin
            for (int i = 0; i < N; i++) begin
                checks++;
                assert (o_data[i] === $signed(rows[0].lanes[i*16 +: 16])) else begin
                    errors++;
                    $error("FAIL lane%0d observed=%0d expected=%0d t=%0t", i, o_data[i],
                           $signed(rows[0].lanes[i*16 +: 16]), $time);
                end
            end
            checks++;
            assert (o_sat === rows[0].sat) else begin
                errors++;
                $error("FAIL o_sat observed=%0b expected=%0b t=%0t", o_sat, rows[0].sat, $time);
            end
            checks++;
            assert (o_pad === rows[0].pad) else begin
                errors++;
                $error("FAIL o_pad observed=%0d expected=%0d t=%0t", o_pad, rows[0].pad, $time);
            end
        end
    endtask

    task automatic check_zero_row();
        for (int i = 0; i < N; i++) begin
            checks++;
            assert (o_data[i] === 16'sd0) else begin
                errors++;
                $error("FAIL reset_lane%0d observed=%0d expected=0", i, o_data[i]);
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic rdy, input logic rst);
        logic acc, pop;
        i_valid = v; i_data = d; i_last = l; i_ready = rdy; i_rst = rst;
        acc = !rst && v && (rows.size() < 2);
        pop = !rst && (rows.size() > 0) && rdy;
        @(posedge i_clk);
        #1;
        if (rst) begin
            rows.delete();
            cur_cnt = 0;
        end else begin
            if (pop) void'(rows.pop_front());
            if (acc) model_accept(d, l);
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [31:0] rnd_vals [5];
    logic [31:0] dv;

    initial begin
        cur = '0; cur_sat = 1'b0; cur_cnt = 0;
        rnd_vals[0] = 32'h00000002; rnd_vals[1] = 32'h00000001; rnd_vals[2] = 32'hFFFFFFFE;
        rnd_vals[3] = 32'hFFFFFFFD; rnd_vals[4] = 32'hFFFE0000;

        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_zero_row();
        idle(2);

        // Alternating 0.0 / 1.0 full row
        for (int k = 0; k < N; k++) step(1'b1, (k % 2) << 16, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Rounding lanes, closed early on the fifth element
        for (int k = 0; k < 5; k++) step(1'b1, rnd_vals[k], (k == 4), 1'b1, 1'b0);
        idle(2);

        // Saturation in lane 5, then a clean row
        for (int k = 0; k < N; k++) step(1'b1, (k == 5) ? 32'h00020000 : 32'h00008000, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) step(1'b1, 32'hFFFF0000, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Short row of 10
        for (int k = 0; k < 10; k++) step(1'b1, 32'h00010000, (k == 9), 1'b1, 1'b0);
        idle(2);

        // i_last on lane N-1 gives pad 0
        for (int k = 0; k < N; k++) step(1'b1, 32'(k) << 12, (k == N-1), 1'b1, 1'b0);
        idle(2);

        // Backpressure: 96 offered with i_ready low, then drain while streaming
        for (int k = 0; k < 96; k++) step(1'b1, 32'($urandom_range(0, 65535)) << 2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 32'($urandom_range(0, 65535)) << 2, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Reset mid-row
        for (int k = 0; k < 17; k++) step(1'b1, 32'h00004000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_zero_row();
        for (int k = 0; k < N; k++) step(1'b1, 32'(k) << 14, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 3))
                0:       dv = $urandom;
                1:       dv = 32'($signed(16'($urandom))) ;
                2:       dv = 32'($signed(18'($urandom)));
                default: dv = 32'($signed(4'($urandom)));
            endcase
            step($urandom_range(0, 9) < 7, dv, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) < 6, 1'b0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
